// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - reservation-station issue scheduler: dual dispatch, tag wakeup, age-ordered select for ALU1/ALU2/MEM.
// Optional perf counters are built when RS_ISSUE_SCHED_PERF_EN is defined.
module rs_issue_sched #(
    parameter int NUM_ENTRIES = 16,
    parameter int PAYLOAD_W   = 96,
    parameter int TAG_W       = 6,
    parameter int ROB_W       = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [1:0]                      disp_valid,
    output logic                            disp_ready,
    input  logic [2*TAG_W-1:0]              disp_src1_tag,
    input  logic [2*TAG_W-1:0]              disp_src2_tag,
    input  logic [1:0]                      disp_src1_rdy,
    input  logic [1:0]                      disp_src2_rdy,
    input  logic [3:0]                      disp_fu,
    input  logic [2*ROB_W-1:0]              disp_rob,
    input  logic [2*PAYLOAD_W-1:0]          disp_payload,
    input  logic [1:0]                      wake_valid,
    input  logic [2*TAG_W-1:0]              wake_tag,
    input  logic [2:0]                      fu_rdy,
    output logic [2:0]                      iss_valid,
    output logic [3*ROB_W-1:0]              iss_rob,
    output logic [3*PAYLOAD_W-1:0]          iss_payload,
    output logic [3*TAG_W-1:0]              iss_src1_tag,
    output logic [3*TAG_W-1:0]              iss_src2_tag,
    output logic [$clog2(NUM_ENTRIES):0]    occupancy
`ifdef RS_ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]                     perf_stall_cnt,
    output logic [31:0]                     perf_issue_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0] valid, rdy1, rdy2;
    logic [1:0]             fu       [NUM_ENTRIES];
    logic [TAG_W-1:0]       src1_tag [NUM_ENTRIES];
    logic [TAG_W-1:0]       src2_tag [NUM_ENTRIES];
    logic [ROB_W-1:0]       rob      [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   payload  [NUM_ENTRIES];
    // older[i][j]: entry i was allocated before entry j
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older;

    logic [1:0]                        acc;
    logic [1:0][IDX_W-1:0]             alloc;
    logic [IDX_W-1:0]                  free0, free1;
    logic                              found0, found1;
    logic [NUM_ENTRIES-1:0]            alu_el, mem_el;
    logic [NUM_ENTRIES-1:0]            sel_alu1, sel_alu2, sel_mem, issued;
    logic [2:0][NUM_ENTRIES-1:0]       sel_all;
    logic [3*ROB_W-1:0]                nxt_rob;
    logic [3*PAYLOAD_W-1:0]            nxt_payload;
    logic [3*TAG_W-1:0]                nxt_src1, nxt_src2;

    function automatic logic wake_hit(input logic [TAG_W-1:0] t, input logic [1:0] wv,
                                      input logic [2*TAG_W-1:0] wt);
        return (wv[0] && wt[0 +: TAG_W] == t) || (wv[1] && wt[TAG_W +: TAG_W] == t);
    endfunction

    function automatic logic [NUM_ENTRIES-1:0] pick_oldest(
        input logic [NUM_ENTRIES-1:0] cand,
        input logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age);
        logic [NUM_ENTRIES-1:0] sel;
        sel = cand;
        for (int i = 0; i < NUM_ENTRIES; i++)
            for (int j = 0; j < NUM_ENTRIES; j++)
                if (cand[j] && age[j][i]) sel[i] = 1'b0;
        return sel;
    endfunction

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            occupancy = occupancy + CNT_W'(valid[i]);
    end

    assign disp_ready = occupancy <= CNT_W'(NUM_ENTRIES - 2);
    assign acc        = (disp_ready && !flush) ? disp_valid : 2'b00;

    // Only entries free at the start of the cycle are candidates, so same-cycle frees are never reused.
    always_comb begin
        free0  = '0;
        free1  = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!valid[i]) begin
                if (!found0) begin
                    free0  = IDX_W'(i);
                    found0 = 1'b1;
                end else if (!found1) begin
                    free1  = IDX_W'(i);
                    found1 = 1'b1;
                end
            end
        end
    end

    assign alloc[0] = free0;
    assign alloc[1] = acc[0] ? free1 : free0;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            alu_el[i] = valid[i] && rdy1[i] && rdy2[i] && fu[i] == 2'b00 && !flush;
            mem_el[i] = valid[i] && rdy1[i] && rdy2[i] && fu[i] == 2'b01 && !flush;
        end
    end

    assign sel_alu1 = fu_rdy[0] ? pick_oldest(alu_el, older) : '0;
    assign sel_alu2 = fu_rdy[1] ? pick_oldest(alu_el & ~sel_alu1, older) : '0;
    assign sel_mem  = fu_rdy[2] ? pick_oldest(mem_el, older) : '0;
    assign issued   = sel_alu1 | sel_alu2 | sel_mem;
    assign sel_all  = {sel_mem, sel_alu2, sel_alu1};

    always_comb begin
        nxt_rob     = '0;
        nxt_payload = '0;
        nxt_src1    = '0;
        nxt_src2    = '0;
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (sel_all[u][i]) begin
                    nxt_rob[u*ROB_W +: ROB_W]             = nxt_rob[u*ROB_W +: ROB_W] | rob[i];
                    nxt_payload[u*PAYLOAD_W +: PAYLOAD_W] = nxt_payload[u*PAYLOAD_W +: PAYLOAD_W] | payload[i];
                    nxt_src1[u*TAG_W +: TAG_W]            = nxt_src1[u*TAG_W +: TAG_W] | src1_tag[i];
                    nxt_src2[u*TAG_W +: TAG_W]            = nxt_src2[u*TAG_W +: TAG_W] | src2_tag[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid        <= '0;
            rdy1         <= '0;
            rdy2         <= '0;
            older        <= '0;
            iss_valid    <= '0;
            iss_rob      <= '0;
            iss_payload  <= '0;
            iss_src1_tag <= '0;
            iss_src2_tag <= '0;
        end else begin
            iss_valid    <= {|sel_mem, |sel_alu2, |sel_alu1};
            iss_rob      <= nxt_rob;
            iss_payload  <= nxt_payload;
            iss_src1_tag <= nxt_src1;
            iss_src2_tag <= nxt_src2;
            if (flush) begin
                valid <= '0;
            end else begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (issued[i]) valid[i] <= 1'b0;
                    if (wake_hit(src1_tag[i], wake_valid, wake_tag)) rdy1[i] <= 1'b1;
                    if (wake_hit(src2_tag[i], wake_valid, wake_tag)) rdy2[i] <= 1'b1;
                end
                for (int k = 0; k < 2; k++) begin
                    if (acc[k]) begin
                        valid[alloc[k]]    <= 1'b1;
                        src1_tag[alloc[k]] <= disp_src1_tag[k*TAG_W +: TAG_W];
                        src2_tag[alloc[k]] <= disp_src2_tag[k*TAG_W +: TAG_W];
                        rdy1[alloc[k]]     <= disp_src1_rdy[k] || disp_src1_tag[k*TAG_W +: TAG_W] == '0 ||
                                              wake_hit(disp_src1_tag[k*TAG_W +: TAG_W], wake_valid, wake_tag);
                        rdy2[alloc[k]]     <= disp_src2_rdy[k] || disp_src2_tag[k*TAG_W +: TAG_W] == '0 ||
                                              wake_hit(disp_src2_tag[k*TAG_W +: TAG_W], wake_valid, wake_tag);
                        fu[alloc[k]]       <= disp_fu[k*2 +: 2];
                        rob[alloc[k]]      <= disp_rob[k*ROB_W +: ROB_W];
                        payload[alloc[k]]  <= disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
                    end
                end
                // New entries are younger than everything; slot 1 is younger than slot 0.
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    for (int j = 0; j < NUM_ENTRIES; j++) begin
                        if (acc[0] && IDX_W'(i) == alloc[0])
                            older[i][j] <= acc[1] && IDX_W'(j) == alloc[1];
                        else if (acc[1] && IDX_W'(i) == alloc[1])
                            older[i][j] <= 1'b0;
                        else if ((acc[0] && IDX_W'(j) == alloc[0]) || (acc[1] && IDX_W'(j) == alloc[1]))
                            older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef RS_ISSUE_SCHED_PERF_EN
    logic [1:0]  n_iss;
    logic [32:0] issue_sum;

    assign n_iss     = 2'(|sel_alu1) + 2'(|sel_alu2) + 2'(|sel_mem);
    assign issue_sum = {1'b0, perf_issue_cnt} + 33'(n_iss);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_issue_cnt <= '0;
        end else begin
            if (|disp_valid && !disp_ready && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            perf_issue_cnt <= issue_sum[32] ? 32'hFFFF_FFFF : issue_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - randomized self-checking bench for rs_issue_sched against an age-ordered queue model.
module tb_rs_issue_sched;
    localparam int NE = 16;
    localparam int TW = 6;
    localparam int RW = 4;
    localparam int PW = 96;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      disp_valid = '0;
    logic            disp_ready;
    logic [2*TW-1:0] disp_src1_tag = '0, disp_src2_tag = '0;
    logic [1:0]      disp_src1_rdy = '0, disp_src2_rdy = '0;
    logic [3:0]      disp_fu = '0;
    logic [2*RW-1:0] disp_rob = '0;
    logic [2*PW-1:0] disp_payload = '0;
    logic [1:0]      wake_valid = '0;
    logic [2*TW-1:0] wake_tag = '0;
    logic [2:0]      fu_rdy = '0;
    logic [2:0]      iss_valid;
    logic [3*RW-1:0] iss_rob;
    logic [3*PW-1:0] iss_payload;
    logic [3*TW-1:0] iss_src1_tag, iss_src2_tag;
    logic [4:0]      occupancy;
`ifdef RS_ISSUE_SCHED_PERF_EN
    logic [31:0]     perf_stall_cnt, perf_issue_cnt;
    int              m_stall = 0, m_issue = 0;
`endif

    rs_issue_sched dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_fu(disp_fu), .disp_rob(disp_rob), .disp_payload(disp_payload),
        .wake_valid(wake_valid), .wake_tag(wake_tag), .fu_rdy(fu_rdy),
        .iss_valid(iss_valid), .iss_rob(iss_rob), .iss_payload(iss_payload),
        .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag),
        .occupancy(occupancy)
`ifdef RS_ISSUE_SCHED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_issue_cnt(perf_issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] t1, t2;
        logic          r1, r2;
        logic [1:0]    fu;
        logic [RW-1:0] rob;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t mq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic hit(input logic [TW-1:0] t);
        return (wake_valid[0] && wake_tag[TW-1:0] == t) || (wake_valid[1] && wake_tag[2*TW-1:TW] == t);
    endfunction

    function automatic int find_oldest(input logic [1:0] code);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && mq[i].r2 && mq[i].fu == code) return i;
        return -1;
    endfunction

    task automatic set_slot(input int k, input logic [TW-1:0] t1, input logic r1, input logic [TW-1:0] t2,
                            input logic r2, input logic [1:0] f, input logic [RW-1:0] r);
        disp_valid[k]           = 1'b1;
        disp_src1_tag[k*TW +: TW] = t1;
        disp_src1_rdy[k]        = r1;
        disp_src2_tag[k*TW +: TW] = t2;
        disp_src2_rdy[k]        = r2;
        disp_fu[k*2 +: 2]       = f;
        disp_rob[k*RW +: RW]    = r;
        disp_payload[k*PW +: PW] = {$urandom, $urandom, $urandom};
    endtask

    task automatic set_wake(input int k, input logic [TW-1:0] t);
        wake_valid[k]        = 1'b1;
        wake_tag[k*TW +: TW] = t;
    endtask

    // Model one clock: issue oldest-first from stored readiness, then wake, then dispatch.
    task automatic step();
        logic [2:0] ev;
        ent_t       pk[3];
        ent_t       e;
        int         idx;
        logic       rdy_m;
        ev    = '0;
        rdy_m = mq.size() <= NE - 2;
`ifdef RS_ISSUE_SCHED_PERF_EN
        if (|disp_valid && !rdy_m) m_stall++;
`endif
        if (flush) begin
            mq.delete();
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (fu_rdy[u]) begin
                    idx = find_oldest(u == 2 ? 2'b01 : 2'b00);
                    if (idx >= 0) begin
                        pk[u] = mq[idx];
                        ev[u] = 1'b1;
                        mq.delete(idx);
                    end
                end
            end
            foreach (mq[i]) begin
                if (hit(mq[i].t1)) mq[i].r1 = 1'b1;
                if (hit(mq[i].t2)) mq[i].r2 = 1'b1;
            end
            if (rdy_m) begin
                for (int k = 0; k < 2; k++) begin
                    if (disp_valid[k]) begin
                        e.t1  = disp_src1_tag[k*TW +: TW];
                        e.t2  = disp_src2_tag[k*TW +: TW];
                        e.r1  = disp_src1_rdy[k] || e.t1 == 0 || hit(e.t1);
                        e.r2  = disp_src2_rdy[k] || e.t2 == 0 || hit(e.t2);
                        e.fu  = disp_fu[k*2 +: 2];
                        e.rob = disp_rob[k*RW +: RW];
                        e.pl  = disp_payload[k*PW +: PW];
                        mq.push_back(e);
                    end
                end
            end
        end
`ifdef RS_ISSUE_SCHED_PERF_EN
        m_issue += int'(ev[0]) + int'(ev[1]) + int'(ev[2]);
`endif
        @(posedge clk);
        #1;
        chk("iss_valid", 128'(iss_valid), 128'(ev));
        for (int u = 0; u < 3; u++) begin
            if (ev[u]) begin
                chk($sformatf("iss_rob%0d", u), 128'(iss_rob[u*RW +: RW]), 128'(pk[u].rob));
                chk($sformatf("iss_payload%0d", u), 128'(iss_payload[u*PW +: PW]), 128'(pk[u].pl));
                chk($sformatf("iss_src1_%0d", u), 128'(iss_src1_tag[u*TW +: TW]), 128'(pk[u].t1));
                chk($sformatf("iss_src2_%0d", u), 128'(iss_src2_tag[u*TW +: TW]), 128'(pk[u].t2));
            end
        end
        chk("occupancy", 128'(occupancy), 128'(mq.size()));
        chk("disp_ready", 128'(disp_ready), 128'(mq.size() <= NE - 2));
`ifdef RS_ISSUE_SCHED_PERF_EN
        chk("perf_stall", 128'(perf_stall_cnt), 128'(m_stall));
        chk("perf_issue", 128'(perf_issue_cnt), 128'(m_issue));
`endif
        disp_valid = '0;
        wake_valid = '0;
        flush      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iss_valid", 128'(iss_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_disp_ready", 128'(disp_ready), 128'(1));
        chk("rst_iss_rob", 128'(iss_rob), 128'(0));
        chk("rst_iss_payload", 128'(iss_payload), 128'(0));
        reset = 1'b0;

        // single ready ALU op: two cycles dispatch to issue
        fu_rdy = 3'b111;
        set_slot(0, 0, 1, 0, 1, 2'b00, 4'd3);
        step();
        chk("t1_occ1", 128'(occupancy), 128'(1));
        step();
        chk("t1_valid", 128'(iss_valid), 128'(3'b001));
        chk("t1_rob", 128'(iss_rob[RW-1:0]), 128'(3));

        // wakeup latency
        set_slot(0, 12, 0, 0, 1, 2'b00, 4'd1);
        repeat (3) step();
        chk("t2_not_early", 128'(iss_valid), 128'(0));
        set_wake(0, 12);
        step();
        chk("t2_wake_edge", 128'(iss_valid), 128'(0));
        step();
        chk("t2_issue", 128'(iss_valid[0]), 128'(1));
        chk("t2_rob", 128'(iss_rob[RW-1:0]), 128'(1));

        // age order across two ALUs
        for (int pass = 0; pass < 2; pass++) begin
            fu_rdy = 3'b000;
            set_slot(0, 0, 1, 0, 1, 2'b00, 4'd4);
            set_slot(1, 0, 1, 0, 1, 2'b00, 4'd5);
            step();
            set_slot(0, 0, 1, 0, 1, 2'b00, 4'd6);
            set_slot(1, 0, 1, 0, 1, 2'b00, 4'd7);
            step();
            fu_rdy = pass == 0 ? 3'b011 : 3'b010;
            step();
            if (pass == 0) begin
                chk("t3_alu1_a", 128'(iss_rob[RW-1:0]), 128'(4));
                chk("t3_alu2_a", 128'(iss_rob[2*RW-1:RW]), 128'(5));
            end else begin
                chk("t3_alu2_only", 128'(iss_valid), 128'(3'b010));
                chk("t3_alu2_oldest", 128'(iss_rob[2*RW-1:RW]), 128'(4));
            end
            step();
            step();
            step();
        end

        // full station: 15 blocked entries
        flush = 1'b1;
        step();
        for (int p = 0; p < 7; p++) begin
            set_slot(0, TW'(33 + 2 * p), 0, 0, 1, 2'b00, RW'(p));
            set_slot(1, TW'(34 + 2 * p), 0, 0, 1, 2'b00, RW'(p + 8));
            step();
        end
        set_slot(0, 47, 0, 0, 1, 2'b00, 4'd15);
        step();
        chk("t4_full_rdy", 128'(disp_ready), 128'(0));
        set_slot(1, 0, 1, 0, 1, 2'b00, 4'd2);
        step();
        chk("t4_drop_occ", 128'(occupancy), 128'(15));
        fu_rdy = 3'b111;
        set_wake(0, 33);
        step();
        step();
        chk("t4_freed_occ", 128'(occupancy), 128'(14));
        chk("t4_freed_rdy", 128'(disp_ready), 128'(1));

        // flush with concurrent dispatch and wake
        flush = 1'b1;
        step();
        for (int p = 0; p < 5; p++) begin
            set_slot(0, 50, 0, 0, 1, 2'b00, RW'(p));
            set_slot(1, 50, 0, 0, 1, 2'b01, RW'(p + 5));
            step();
        end
        set_slot(0, 0, 1, 0, 1, 2'b00, 4'd1);
        set_slot(1, 0, 1, 0, 1, 2'b01, 4'd2);
        set_wake(0, 50);
        flush = 1'b1;
        step();
        chk("t5_flush_occ", 128'(occupancy), 128'(0));
        chk("t5_flush_iss", 128'(iss_valid), 128'(0));
        step();

        // dispatch bypass from a same-cycle wake
        set_slot(0, 0, 1, 20, 0, 2'b00, 4'd9);
        set_wake(1, 20);
        step();
        step();
        chk("t6_bypass_valid", 128'(iss_valid), 128'(3'b001));
        chk("t6_bypass_rob", 128'(iss_rob[RW-1:0]), 128'(9));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            fu_rdy = 3'($urandom);
            if ($urandom_range(0, 59) == 0) flush = 1'b1;
            if (mq.size() <= NE - 2) begin
                for (int k = 0; k < 2; k++) begin
                    if ($urandom_range(0, 1) == 1)
                        set_slot(k, TW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                 TW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                 2'($urandom_range(0, 1)), RW'($urandom));
                end
            end
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 1) == 1) set_wake(k, TW'($urandom_range(1, 15)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Issue scheduler for the reservation station of the dual-dispatch out-of-order core. Accepts up to two renamed instructions per cycle from dispatch and holds them until both source physical registers are ready. Wakes waiting sources from completion broadcasts. Each cycle it selects the oldest ready instruction for each free functional unit (ALU1, ALU2, MEM) and presents it, registered, to the register-read/issue stage.

## Interface
- `NUM_ENTRIES`, 16, number of station entries (power of two, ≥4)
- `PAYLOAD_W`, 96, opaque per-instruction payload width (pc/imm/ALUCtrl/control/rd/rd_old), carried unmodified
- `TAG_W`, 6, physical register tag width
- `ROB_W`, 4, ROB index width
- `clk` in 1 — clock; all state updates on rising edge
- `reset` in 1 — synchronous, active-high
- `flush` in 1 — synchronous squash of all entries
- `disp_valid` in 2 — per-slot dispatch request; slot 0 is older than slot 1
- `disp_ready` out 1 — high when ≥2 entries are free
- `disp_src1_tag`, `disp_src2_tag` in 2×TAG_W — source physical tags
- `disp_src1_rdy`, `disp_src2_rdy` in 2 — source already available at rename
- `disp_fu` in 2×2 — `2'b00` ALU (either), `2'b01` MEM; other codes illegal
- `disp_rob` in 2×ROB_W — ROB index
- `disp_payload` in 2×PAYLOAD_W
- `wake_valid` in 2 — completion broadcasts (ALU and MEM complete ports)
- `wake_tag` in 2×TAG_W — completed destination tag
- `fu_rdy` in 3 — {mem, alu2, alu1} can accept an instruction this cycle
- `iss_valid` out 3 — {mem, alu2, alu1} issue valid
- `iss_rob` out 3×ROB_W; `iss_payload` out 3×PAYLOAD_W; `iss_src1_tag`, `iss_src2_tag` out 3×TAG_W
- `occupancy` out log2(NUM_ENTRIES)+1 — valid entry count

## Operation
- Entry: valid, src1 tag/rdy, src2 tag/rdy, fu, rob, payload. Age is tracked by an NUM_ENTRIES² age matrix: `older[i][j]` is set when i was allocated before j.
- Allocation: when `disp_ready`, each valid slot takes the lowest-index free entry (slot 1 takes the next one). Slot 1 is younger than slot 0 and younger than all resident entries. Slot 1 may be valid without slot 0. `disp_valid` while `!disp_ready` is dropped; the bench flags it as a protocol error.
- Tag 0 (x0) is always ready at allocation.
- Wakeup: any valid entry whose source tag equals a valid `wake_tag` sets that rdy bit. Dispatch bypass: a dispatching source that matches a same-cycle `wake_tag` is stored ready.
- Eligibility: valid, both stored rdy bits are 1, and the entry was not issued this cycle. Selection uses stored bits only, so an entry woken at edge k is eligible in the cycle after k.
- Select (combinational, from current state):
  - ALU1 takes the oldest eligible ALU entry if `fu_rdy[0]`.
  - ALU2 takes the oldest eligible ALU entry not taken by ALU1 if `fu_rdy[1]`. If `fu_rdy[0]`=0, ALU2 takes the oldest.
  - MEM takes the oldest eligible MEM entry if `fu_rdy[2]`.
- Selected entries are invalidated at the edge and their fields registered onto `iss_*`. `iss_valid[k]`=0 for any unit with no selection.
- Free and allocate in the same cycle: a freed entry is not reusable until the next cycle. `disp_ready` is computed from the current free count.
- Flush: at the edge, all entries are invalidated, `iss_valid` is cleared, and dispatch and wakeup that cycle are ignored. `reset` has priority over `flush`.

## Timing
- Reset values: all entries invalid, `iss_valid`=0, `iss_*` data 0, `occupancy`=0, `disp_ready`=1.
- Dispatch with both sources ready, accepted at edge k: earliest `iss_valid` is after edge k+1 (2-cycle dispatch→issue).
- Wake at edge k: the entry can issue after edge k+1.
- `iss_*` holds for exactly one cycle per issue; there is no backpressure after issue (`fu_rdy` is the only throttle).
- `occupancy` after an edge = previous + accepted dispatches − issues; it is 0 after flush.
- Full: with NUM_ENTRIES−1 entries valid, `disp_ready`=0, even when only one slot would be used.

## Configuration
- `RS_ISSUE_SCHED_PERF_EN` defined: adds outputs `perf_stall_cnt` (32) and `perf_issue_cnt` (32), both saturating, reset to 0 and unaffected by flush.
  - `perf_stall_cnt` counts cycles with `|disp_valid && !disp_ready`.
  - `perf_issue_cnt` adds popcount(next `iss_valid`) each cycle.
- Undefined: those ports and counters do not exist. Functional behaviour is identical.

## Test plan
- Reset, then dispatch slot0 ALU rob=3 (both rdy) with `fu_rdy`=3'b111 → two cycles later `iss_valid`=3'b001, `iss_rob[0]`=3. `occupancy` goes 0→1→0.
- Dispatch ALU rob=1 (src1 tag=12 not ready), then `wake_tag`=12 at edge k → `iss_valid[0]`=1 with rob=1 after edge k+1, never earlier.
- Fill 4 ready ALU entries rob=4,5,6,7 in age order, `fu_rdy`=3'b011 → ALU1 issues rob 4, ALU2 issues rob 5; next cycle ALU1 issues 6, ALU2 issues 7. With `fu_rdy`=3'b010, only ALU2 issues, oldest first.
- Fill to NUM_ENTRIES−1 (15) with blocked sources → `disp_ready`=0. Slot dispatch is dropped and occupancy stays 15. One wake frees an entry → `disp_ready`=1 after issue.
- 10 entries resident, assert `flush` together with `disp_valid`=2'b11 and a matching wake → next cycle `occupancy`=0, `iss_valid`=0, and no entry allocated.
- Same-cycle dispatch src2 tag=20 and `wake_tag[1]`=20 → entry stored ready and issues 2 cycles after dispatch. With `RS_ISSUE_SCHED_PERF_EN`, `perf_issue_cnt` increments by 1.
